approx_div_mae_monitor: RTL
===========================

// Module: approx_div_mae_monitor
// PURPOSE
// - Downstream consumer of the 16/8 approximate array divider: takes each operand pair (n,d) with the
//   divider's approximate q,r, computes the exact q,r with an internal sequential restoring divider,
//   and accumulates error statistics (sample count, sum/max |q err|, sum |r err|).
// - Used in characterisation benches and on-chip sign-off of approximate divider variants.
// PARAMETERS
// - N_W    16  dividend width; divisor, quotient and remainder are N_W/2
// - ACC_W  32  width of the error-sum accumulators (saturating)
// - CNT_W  24  width of the sample and skip counters (saturating)
// PORTS
// - clk        in   1        single clock, rising edge
// - rst        in   1        asynchronous, active-high reset
// - in_valid   in   1        sample offered
// - in_ready   out  1        monitor can accept; high only in IDLE
// - in_n       in   N_W      dividend fed to the divider under test
// - in_d       in   N_W/2    divisor
// - in_q       in   N_W/2    approximate quotient from the divider under test
// - in_r       in   N_W/2    approximate remainder from the divider under test
// - clear      in   1        synchronous zeroing of all statistics
// - busy       out  1        high in CALC or ACCUM
// - sample_cnt out  CNT_W    accumulated valid samples
// - skip_cnt   out  CNT_W    rejected samples (d==0 or quotient overflow)
// - err_q_sum  out  ACC_W    sum of |q_exact - in_q|
// - err_q_max  out  N_W/2    max of |q_exact - in_q|
// - err_r_sum  out  ACC_W    sum of |r_exact - in_r|
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, busy=0, every counter/accumulator/max = 0; reset mid-CALC discards the sample.
// - FSM IDLE -> CALC -> ACCUM -> IDLE. Accept = in_valid & in_ready at an edge; operands captured.
// - At accept, d==0 or n[15:8] >= d (quotient exceeds N_W/2 bits) => skip: skip_cnt+1, stay in IDLE.
// - Otherwise CALC: rem (N_W/2+1 bits) starts at n[15:8]; one restoring step per cycle, N_W/2 cycles:
//   t = {rem[N_W/2-1:0], next n bit MSB-first}; if t >= d then rem = t-d, qbit=1 else rem = t, qbit=0.
// - ACCUM (1 cycle): |q_exact-in_q| and |r_exact-in_r| computed unsigned (N_W/2 bits) from captured in_q/in_r;
//   sample_cnt+1, sums added, max updated; return to IDLE.
// - Latency: accept at edge 0 -> CALC edges 1..8 -> ACCUM at edge 9 -> stats visible, in_ready=1 after edge 10.
//   Throughput one sample per 10 cycles for N_W=16.
// - in_valid while busy is ignored (no capture, no count); inputs may change freely after accept.
// - All counters/sums saturate at all-ones; no wrap.
// - clear: zeroes all statistics at the edge; FSM unaffected, in-flight sample still accumulates later.
//   clear coincident with ACCUM or with a skip: clear wins, that sample is dropped entirely.
// STRUCTURE
// - Package approx_div_pkg: state enum {IDLE,CALC,ACCUM}, DIV_N_W/DIV_D_W constants, abs_diff function.
// - Sub-module seq_restoring_div: start/done handshake, n, d in; q, r out; reused by other monitors.
// - Top: FSM, operand capture, skip detection, error datapath, saturating accumulators.
// TESTING
// - Reset: assert rst mid-CALC -> all outputs 0, in_ready=1 immediately (async), next sample works.
// - n=100,d=7,q=14,r=2 -> after 10 cycles sample_cnt=1, err_q_sum=0, err_r_sum=0, err_q_max=0.
// - n=100,d=7,q=13,r=9 -> err_q_sum=1, err_r_sum=7, err_q_max=1; then n=0x00FF,d=1,q=0xF0,r=0 ->
//   err_q_sum=16, err_q_max=15, sample_cnt=2.
// - d=0 and n=0x0800,d=8 -> skip_cnt=2, sample_cnt unchanged, in_ready never drops.
// - Hold in_valid high with changing operands during CALC -> only first sample counted; error uses captured q/r.
// - ACC_W=8: 20 samples each with |q err|=15 -> err_q_sum saturates at 255; clear on ACCUM cycle -> all 0, sample dropped.

Source files
------------

// File: rtl/approx_div_pkg.sv
// approx_div_pkg: shared types, widths and helpers for approximate-divider monitors
package approx_div_pkg;
  localparam int DIV_N_W = 16;
  localparam int DIV_D_W = DIV_N_W / 2;
  typedef enum logic [1:0] {IDLE, CALC, ACCUM} state_e;
  function automatic logic [DIV_D_W-1:0] abs_diff(input logic [DIV_D_W-1:0] a, input logic [DIV_D_W-1:0] b);
    return a >= b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/seq_restoring_div.sv
// seq_restoring_div: N_W/N_W/2 restoring divider, one quotient bit per cycle, done pulses when q/r are valid
module seq_restoring_div #(
  parameter int N_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic [N_W/2-1:0] d,
  output logic             done,
  output logic [N_W/2-1:0] q,
  output logic [N_W/2-1:0] r
);
  localparam int D_W = N_W / 2;
  localparam int C_W = $clog2(D_W + 1);
  logic [D_W-1:0] rem_q, sh_q, d_q;
  logic [C_W-1:0] cnt_q;
  logic           done_q;
  logic [D_W:0]   t;
  logic           ge;
  assign t    = {rem_q, sh_q[D_W-1]};
  assign ge   = t >= {1'b0, d_q};
  assign done = done_q;
  assign q    = sh_q;
  assign r    = rem_q;
  // quotient bits shift into sh_q as the dividend's low bits shift out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      sh_q   <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= cnt_q == C_W'(1);
      if (start) begin
        rem_q <= n[N_W-1:D_W];
        sh_q  <= n[D_W-1:0];
        d_q   <= d;
        cnt_q <= C_W'(D_W);
      end else if (cnt_q != '0) begin
        rem_q <= ge ? D_W'(t - {1'b0, d_q}) : t[D_W-1:0];
        sh_q  <= {sh_q[D_W-2:0], ge};
        cnt_q <= cnt_q - C_W'(1);
      end
    end
  end
endmodule

// File: rtl/approx_div_mae_monitor.sv
// approx_div_mae_monitor: recomputes exact q/r for each sample of an approximate divider
// and accumulates saturating error statistics.
module approx_div_mae_monitor
  import approx_div_pkg::*;
#(
  parameter int N_W   = DIV_N_W,
  parameter int ACC_W = 32,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   in_n,
  input  logic [N_W/2-1:0] in_d,
  input  logic [N_W/2-1:0] in_q,
  input  logic [N_W/2-1:0] in_r,
  input  logic             clear,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [ACC_W-1:0] err_q_sum,
  output logic [N_W/2-1:0] err_q_max,
  output logic [ACC_W-1:0] err_r_sum
);
  localparam int D_W = N_W / 2;
  state_e           state_q;
  logic [D_W-1:0]   q_cap_q, r_cap_q, q_ex, r_ex, eq, er, err_q_max_q;
  logic [CNT_W-1:0] sample_cnt_q, skip_cnt_q;
  logic [ACC_W-1:0] err_q_sum_q, err_r_sum_q, err_q_sum_d, err_r_sum_d;
  logic [ACC_W:0]   q_add, r_add;
  logic             accept, skip, start, done;
  assign in_ready   = state_q == IDLE;
  assign busy       = !in_ready;
  assign accept     = in_valid && in_ready;
  assign skip       = in_d == '0 || in_n[N_W-1:D_W] >= in_d;
  assign start      = accept && !skip;
  assign sample_cnt = sample_cnt_q;
  assign skip_cnt   = skip_cnt_q;
  assign err_q_sum  = err_q_sum_q;
  assign err_q_max  = err_q_max_q;
  assign err_r_sum  = err_r_sum_q;
  seq_restoring_div #(.N_W(N_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .n    (in_n),
    .d    (in_d),
    .done (done),
    .q    (q_ex),
    .r    (r_ex)
  );
  always_comb begin
    eq          = abs_diff(q_ex, q_cap_q);
    er          = abs_diff(r_ex, r_cap_q);
    q_add       = {1'b0, err_q_sum_q} + (ACC_W+1)'(eq);
    r_add       = {1'b0, err_r_sum_q} + (ACC_W+1)'(er);
    err_q_sum_d = q_add[ACC_W] ? '1 : q_add[ACC_W-1:0];
    err_r_sum_d = r_add[ACC_W] ? '1 : r_add[ACC_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      q_cap_q      <= '0;
      r_cap_q      <= '0;
      sample_cnt_q <= '0;
      skip_cnt_q   <= '0;
      err_q_sum_q  <= '0;
      err_q_max_q  <= '0;
      err_r_sum_q  <= '0;
    end else begin
      state_q <= start ? CALC : (state_q == CALC && done) ? ACCUM : state_q == ACCUM ? IDLE : state_q;
      if (start) begin
        q_cap_q <= in_q;
        r_cap_q <= in_r;
      end
      // clear beats a same-cycle skip or accumulate, dropping that sample
      if (clear) begin
        sample_cnt_q <= '0;
        skip_cnt_q   <= '0;
        err_q_sum_q  <= '0;
        err_q_max_q  <= '0;
        err_r_sum_q  <= '0;
      end else begin
        if (accept && skip) skip_cnt_q <= &skip_cnt_q ? skip_cnt_q : skip_cnt_q + CNT_W'(1);
        if (state_q == ACCUM) begin
          sample_cnt_q <= &sample_cnt_q ? sample_cnt_q : sample_cnt_q + CNT_W'(1);
          err_q_sum_q  <= err_q_sum_d;
          err_r_sum_q  <= err_r_sum_d;
          err_q_max_q  <= eq > err_q_max_q ? eq : err_q_max_q;
        end
      end
    end
  end
endmodule
